// File: rtl/port_responder_if.sv
// ============================================================================
// Module      : port_responder_if
// Description : CPU port bus plus TX/RX valid-ready links for port_responder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface port_responder_if #(
    parameter int WORD_SIZE = 16
);
    logic [WORD_SIZE-1:0] portaddr;
    logic [WORD_SIZE-1:0] portval;
    logic                 portget;
    logic                 portset;
    logic [WORD_SIZE-1:0] portout;
    logic [WORD_SIZE-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [WORD_SIZE-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output portaddr, portval, portget, portset, tx_ready, rx_data, rx_valid,
        input  portout, tx_data, tx_valid, rx_ready
    );

    modport slave (
        input  portaddr, portval, portget, portset, tx_ready, rx_data, rx_valid,
        output portout, tx_data, tx_valid, rx_ready
    );
endinterface

`default_nettype wire

// File: rtl/port_responder.sv
// ============================================================================
// Module      : port_responder
// Description : Port-bus target with DATA/STATUS/CONTROL window, TX and RX
//               FIFOs. Optional irq output under PORT_RESPONDER_IRQ_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module port_responder #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] BASE_ADDR = 16'h0010,
    parameter int                   DEPTH     = 4
) (
    input  wire logic         clk,
    input  wire logic         do_reset_n,
    port_responder_if.slave   bus
`ifdef PORT_RESPONDER_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int         c_AW    = $clog2(DEPTH);
    localparam logic [3:0] c_DEPTH = 4'(DEPTH);

    // Reset asserts asynchronously and releases on a clock edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge do_reset_n) begin
        if (!do_reset_n) r_rst_sync <= 2'b00;
        else             r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    logic [WORD_SIZE-1:0] w_off;
    logic                 w_in_win;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_wr_data;
    logic                 w_wr_ctrl;
    logic                 w_rd_data;

    // Unsigned subtraction makes addresses below the base wrap out of range.
    assign w_off     = bus.portaddr - BASE_ADDR;
    assign w_in_win  = (w_off < WORD_SIZE'(3));
    assign w_wr      = bus.portset & w_in_win;
    assign w_rd      = bus.portget & ~bus.portset & w_in_win;
    assign w_wr_data = w_wr && (w_off[1:0] == 2'd0);
    assign w_wr_ctrl = w_wr && (w_off[1:0] == 2'd2);
    assign w_rd_data = w_rd && (w_off[1:0] == 2'd0);

    logic [WORD_SIZE-1:0] r_tx_mem [DEPTH];
    logic [c_AW-1:0]      r_tx_wr;
    logic [c_AW-1:0]      r_tx_rd;
    logic [3:0]           r_tx_count;
    logic [WORD_SIZE-1:0] r_rx_mem [DEPTH];
    logic [c_AW-1:0]      r_rx_wr;
    logic [c_AW-1:0]      r_rx_rd;
    logic [3:0]           r_rx_count;
    logic                 r_txovf;
    logic                 r_rxunf;
    logic                 r_irq_en;
    logic [WORD_SIZE-1:0] r_portout;

    logic w_tx_full;
    logic w_tx_empty;
    logic w_tx_push;
    logic w_tx_pop;
    logic w_tx_flush;
    logic w_rx_full;
    logic w_rx_nonempty;
    logic w_rx_push;
    logic w_rx_pop;
    logic w_rx_flush;

    assign w_tx_full     = (r_tx_count == c_DEPTH);
    assign w_tx_empty    = (r_tx_count == 4'd0);
    assign w_tx_push     = w_wr_data & ~w_tx_full;
    assign w_tx_pop      = ~w_tx_empty & bus.tx_ready;
    assign w_tx_flush    = w_wr_ctrl & bus.portval[1];
    assign w_rx_full     = (r_rx_count == c_DEPTH);
    assign w_rx_nonempty = (r_rx_count != 4'd0);
    assign w_rx_pop      = w_rd_data & w_rx_nonempty;
    // A full RX still takes a word when the CPU pops in the same cycle.
    assign w_rx_push     = bus.rx_valid & (~w_rx_full | w_rx_pop);
    assign w_rx_flush    = w_wr_ctrl & bus.portval[2];

    assign bus.tx_valid  = ~w_tx_empty;
    assign bus.tx_data   = w_tx_empty ? '0 : r_tx_mem[r_tx_rd];
    assign bus.rx_ready  = ~w_rx_full;
    assign bus.portout   = r_portout;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tx_wr    <= '0;
            r_tx_rd    <= '0;
            r_tx_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_tx_mem[i] <= '0;
        end else if (w_tx_flush) begin
            r_tx_wr    <= '0;
            r_tx_rd    <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_mem[r_tx_wr] <= bus.portval;
                r_tx_wr           <= r_tx_wr + 1'b1;
            end
            if (w_tx_pop) r_tx_rd <= r_tx_rd + 1'b1;
            r_tx_count <= r_tx_count + {3'b000, w_tx_push} - {3'b000, w_tx_pop};
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_wr    <= '0;
            r_rx_rd    <= '0;
            r_rx_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_rx_mem[i] <= '0;
        end else if (w_rx_flush) begin
            r_rx_wr    <= '0;
            r_rx_rd    <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_mem[r_rx_wr] <= bus.rx_data;
                r_rx_wr           <= r_rx_wr + 1'b1;
            end
            if (w_rx_pop) r_rx_rd <= r_rx_rd + 1'b1;
            r_rx_count <= r_rx_count + {3'b000, w_rx_push} - {3'b000, w_rx_pop};
        end
    end

    logic [15:0]          w_status;
    logic [WORD_SIZE-1:0] w_rd_val;

    assign w_status = {r_tx_count, r_rx_count, 2'b00, r_irq_en, r_rxunf, r_txovf,
                       w_tx_empty, w_tx_full, w_rx_nonempty};

    always_comb begin
        w_rd_val = '0;
        case (w_off[1:0])
            2'd0:    w_rd_val = w_rx_nonempty ? r_rx_mem[r_rx_rd] : '0;
            2'd1:    w_rd_val = WORD_SIZE'(w_status);
            2'd2:    w_rd_val = WORD_SIZE'({12'h000, r_irq_en, 3'b000});
            default: w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_txovf   <= 1'b0;
            r_rxunf   <= 1'b0;
            r_irq_en  <= 1'b0;
            r_portout <= '0;
        end else begin
            if (w_rd) r_portout <= w_rd_val;
            if (w_wr_ctrl) begin
                r_irq_en <= bus.portval[3];
                if (bus.portval[0]) begin
                    r_txovf <= 1'b0;
                    r_rxunf <= 1'b0;
                end
            end
            if (w_wr_data && w_tx_full)     r_txovf <= 1'b1;
            if (w_rd_data && !w_rx_nonempty) r_rxunf <= 1'b1;
        end
    end

`ifdef PORT_RESPONDER_IRQ_EN
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) irq <= 1'b0;
        else          irq <= r_irq_en & (w_rx_nonempty | r_txovf);
    end
`endif

endmodule

`default_nettype wire
